// File: rtl/regfile_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_wr_arbiter_if
//   Bundles the two writeback request channels (A = ALU, B = load/memory)
//   and the registered register-file write command they share.
//
//   Request channel X in {a, b}:
//     x_valid  requester -> arbiter  write pending
//     x_ready  arbiter -> requester  request accepted this cycle
//     x_addr   requester -> arbiter  destination register
//     x_data   requester -> arbiter  write data
//   Write command (arbiter -> register file):
//     wa3 / wd3 / we3                address / data / enable, registered
//
//   Modports: slave = arbiter side, master = requester/register-file side.
// ---------------------------------------------------------------------------
interface regfile_wr_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;

  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;

  logic [ADDR_W-1:0] wa3;
  logic [DATA_W-1:0] wd3;
  logic              we3;

  modport slave (
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    output a_ready, b_ready,
    output wa3, wd3, we3
  );

  modport master (
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    input  a_ready, b_ready,
    input  wa3, wd3, we3
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wr_arbiter
//   Round-robin arbiter sharing the single register-file write port between
//   the ALU writeback (A) and the load writeback (B). A granted request is
//   registered onto wa3/wd3/we3 one cycle after its handshake. Writes to the
//   zero register complete their handshake but never raise we3; they are
//   counted in a saturating drop counter instead.
//
//   Ports:
//     clk         rising-edge clock
//     reset       synchronous, active-high reset
//     stall       blocks all grants for the cycle
//     bus         request channels + write command (slave modport)
//     last_grant  side granted most recently (0 = A, 1 = B)
//     drop_cnt    saturating count of accepted zero-register writes
// ---------------------------------------------------------------------------
module regfile_wr_arbiter #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31,
  parameter int CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  regfile_wr_arbiter_if.slave  bus,
  output logic                 last_grant,
  output logic [CNT_W-1:0]     drop_cnt
);

  typedef enum logic {
    SIDE_A = 1'b0,
    SIDE_B = 1'b1
  } side_e;

  side_e             prio;       // side preferred when both are valid
  side_e             last_side;
  logic              grant_a;
  logic              grant_b;
  logic              hs;
  side_e             hs_side;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_zero;
  logic [ADDR_W-1:0] wa_q;
  logic [DATA_W-1:0] wd_q;
  logic              we_q;

  // Grants already include valid, so a grant is exactly a handshake.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!reset && !stall) begin
      if (bus.a_valid && (!bus.b_valid || prio == SIDE_A)) begin
        grant_a = 1'b1;
      end else if (bus.b_valid) begin
        grant_b = 1'b1;
      end
    end
  end

  assign bus.a_ready = grant_a;
  assign bus.b_ready = grant_b;

  assign hs       = grant_a | grant_b;
  assign hs_side  = grant_b ? SIDE_B : SIDE_A;
  assign sel_addr = grant_b ? bus.b_addr : bus.a_addr;
  assign sel_data = grant_b ? bus.b_data : bus.a_data;
  assign sel_zero = (sel_addr == ADDR_W'(ZERO_REG));

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      prio      <= SIDE_A;
      last_side <= SIDE_A;
      wa_q      <= '0;
      wd_q      <= '0;
      we_q      <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      we_q <= 1'b0;
      if (hs) begin
        // Hand priority to the other side so a persistent pair alternates.
        prio      <= (hs_side == SIDE_A) ? SIDE_B : SIDE_A;
        last_side <= hs_side;
        wa_q      <= sel_addr;
        wd_q      <= sel_data;
        we_q      <= !sel_zero;
        if (sel_zero && drop_cnt != {CNT_W{1'b1}}) begin
          drop_cnt <= drop_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.wa3    = wa_q;
  assign bus.wd3    = wd_q;
  assign bus.we3    = we_q;
  assign last_grant = last_side;

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
Shares the single write port (wa3/wd3/we3) of the 32x64-bit register file between two writeback requesters: A (ALU writeback) and B (load/memory writeback). It uses round-robin arbitration with valid/ready handshakes and drives a registered write command into the register file. Writes to the zero register (X31/XZR) are accepted but suppressed and counted. The block sits between the writeback stage and the register file.

Parameters:
DATA_W, 64, width of write data
ADDR_W, 5, width of register address
ZERO_REG, 31, register index whose writes are discarded
CNT_W, 8, width of the dropped-write counter

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  when 1, no grants are issued this cycle
a_valid  input  1  requester A has a write pending
a_ready  output  1  A's request is accepted this cycle
a_addr  input  ADDR_W  A destination register
a_data  input  DATA_W  A write data
b_valid  input  1  requester B has a write pending
b_ready  output  1  B's request is accepted this cycle
b_addr  input  ADDR_W  B destination register
b_data  input  DATA_W  B write data
wa3  output  ADDR_W  register file write address (registered)
wd3  output  DATA_W  register file write data (registered)
we3  output  1  register file write enable (registered)
last_grant  output  1  0 = A, 1 = B; the requester granted most recently
drop_cnt  output  CNT_W  count of accepted XZR writes; saturating

Behaviour:
- Reset (reset=1 at a rising edge): we3=0, wa3=0, wd3=0, prio=0 (A preferred), last_grant=0, drop_cnt=0. a_ready=b_ready=0 while reset=1.
- a_ready and b_ready are combinational from a_valid, b_valid, stall, reset and prio. At most one of them is 1 in any cycle.
- Grant rules, applied when stall=0 and reset=0:
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant A if prio=0, otherwise grant B.
  - Neither valid: no grant.
- stall=1: both readies are 0, no grant, and we3=0 on the next edge.
- Handshake = valid & ready at a rising edge. Requesters hold valid, addr and data stable until the handshake. Valid must not drop before it is accepted.
- On a handshake with side S at edge N:
  - prio becomes the opposite of S.
  - last_grant becomes S.
  - wa3 and wd3 load S's addr and data.
  - we3 becomes 1 unless addr==ZERO_REG.
  - The register file commits the write at edge N+1. Latency is 1 cycle from handshake to we3 asserted, and 2 edges to the data being readable.
- No handshake at edge N: we3 becomes 0 and wa3/wd3 hold their previous values.
- Zero-register write: the handshake completes normally, but we3=0 and drop_cnt increments. drop_cnt saturates at 2^CNT_W-1 and does not wrap.
- Throughput: one write per cycle. With both requesters continuously valid, grants alternate A,B,A,B. Neither side waits more than 1 cycle.
- prio updates only on a handshake. Idle cycles and stall cycles preserve it.
- Reset during traffic: any request in flight is not accepted. we3 is 0 from the next edge. Requesters must re-present the request after reset drops.

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> we3=0, wa3=0, wd3=0, drop_cnt=0, a_ready=b_ready=0. After release, with no valids, we3 stays 0.
- Single write: A valid, addr=18, data=69 -> a_ready=1 in the same cycle. Next cycle we3=1, wa3=18, wd3=69. The register file read of 18 returns 69 after the following edge. last_grant=0.
- Contention: A and B both valid for 4 cycles from reset (A addr=1/data=10, B addr=2/data=20) -> grant order A,B,A,B. we3 stays high continuously, with wa3 sequence 1,2,1,2.
- Zero register: B writes addr=31, data=9 -> b_ready=1, we3 stays 0 next cycle, drop_cnt increments by 1. Forcing 300 such writes leaves drop_cnt saturated at 255.
- Stall: both valid with stall=1 for 3 cycles -> readies 0 and we3 0. After stall drops, the side indicated by the preserved prio is granted first.
- Reset mid-burst: assert reset while A is granted -> we3=0 the following cycle and prio=0. A's held request is re-accepted after reset is released.
